// File: rtl/apb_master.sv
// APB master: bridges a valid/ready command port to an APB IDLE/SETUP/ACCESS bus cycle.
// Optional ACCESS watchdog compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pselx,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  pselx_q, pselx_d;
   logic                  penable_q, penable_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic accept;
   logic complete;
   logic timeout;

   // cmd_ready is a register so it stays low during reset and rises on the first edge after release.
   assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
   assign complete = (state_q == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SETUP) begin
         cnt_d = '0;
      end else if ((state_q == ACCESS) && !pready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Fires on the last permitted wait cycle; a pready in that same cycle takes priority.
   assign timeout = (state_q == ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pselx_q     <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (complete || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cmd_ready_d = (state_d == IDLE);
      pselx_d     = (state_d != IDLE);
      penable_d   = (state_d == ACCESS);
      rsp_valid_d = complete || timeout;
      if (accept) begin
         paddr_d  = cmd_addr;
         pwrite_d = cmd_write;
         pwdata_d = cmd_wdata;
      end
      if (complete) begin
         rsp_err_d   = pslverr;
         rsp_rdata_d = pwrite_q ? '0 : prdata;
      end else if (timeout) begin
         rsp_err_d   = 1'b1;
         rsp_rdata_d = '0;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign pselx     = pselx_q;
   assign penable   = penable_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: driver pushes expected responses, an APB slave model
// answers with pre-chosen wait states, and a monitor pops and compares on rsp_valid.
module tb_apb_master;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic          pclk = 1'b0;
   logic          presetn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic          pselx;
   logic          penable;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;

   always #5 pclk = ~pclk;

   apb_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .paddr    (paddr),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .pselx    (pselx),
      .penable  (penable),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int unsigned   waits;
      logic [DW-1:0] rdata;
      logic          err;
   } txn_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int unsigned   acc;
   } exp_t;

   txn_t        slv_q[$];
   exp_t        exp_q[$];
   int          nvec = 0;
   int          nerr = 0;
   int unsigned cyc = 0;
   int unsigned acc_cnt = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: slave raises pready on access cycle (waits+1); the watchdog cuts in once waits reach the limit.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      if (TIMEOUT_ON && t.waits >= TO) begin
         e.rdata = '0;
         e.err   = 1'b1;
         e.acc   = TO;
      end else begin
         e.rdata = t.wr ? '0 : t.rdata;
         e.err   = t.err;
         e.acc   = t.waits + 1;
      end
      return e;
   endfunction

   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int unsigned waits, input logic [DW-1:0] rdata, input logic err,
                        output int unsigned acc_at);
      txn_t t;
      int unsigned n = 0;
      acc_at = 0;
      @(negedge pclk);
      while (!cmd_ready && n < 300) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = AW'($urandom);
         cmd_wdata = $urandom;
         @(negedge pclk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
         return;
      end
      t.wr = wr; t.addr = addr; t.wdata = wdata; t.waits = waits; t.rdata = rdata; t.err = err;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      slv_q.push_back(t);
      exp_q.push_back(model(t));
      acc_at = cyc;
   endtask

   task automatic idle_cycles(input int unsigned n);
      repeat (n) begin
         @(negedge pclk);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_access();
      int unsigned n = 0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      while (!(pselx && penable) && n < 20) begin
         @(negedge pclk);
         n++;
      end
      chk("reach_access", 64'(pselx && penable), 64'(1));
   endtask

   // APB slave model
   initial begin
      txn_t cur;
      bit   have_cur = 1'b0;
      bit   prev_setup = 1'b0;
      forever begin
         @(negedge pclk);
         if (!presetn) begin
            pready     = 1'b0;
            prev_setup = 1'b0;
            have_cur   = 1'b0;
            continue;
         end
         if (prev_setup) chk("setup_one_cycle", 64'({pselx, penable}), 64'(2'b11));
         prev_setup = pselx && !penable;
         if (pselx && !penable) begin
            chk("setup_has_txn", 64'(slv_q.size() > 0), 64'(1));
            if (slv_q.size() > 0) begin
               cur      = slv_q.pop_front();
               have_cur = 1'b1;
               acc_cnt  = 0;
               chk("setup_paddr", 64'(paddr), 64'(cur.addr));
               chk("setup_pwrite", 64'(pwrite), 64'(cur.wr));
               chk("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
            end
         end
         if (pselx && penable && have_cur) begin
            chk("access_paddr", 64'(paddr), 64'(cur.addr));
            chk("access_pwrite", 64'(pwrite), 64'(cur.wr));
            chk("access_pwdata", 64'(pwdata), 64'(cur.wdata));
            if (acc_cnt == cur.waits) begin
               pready  = 1'b1;
               prdata  = cur.rdata;
               pslverr = cur.err;
            end else begin
               pready  = 1'b0;
               prdata  = $urandom;
               pslverr = 1'($urandom_range(0, 1));
            end
            acc_cnt++;
         end else begin
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
         end
      end
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (presetn) begin
            if (cmd_ready) chk("idle_bus", 64'({pselx, penable}), 64'(0));
            if (rsp_valid) begin
               chk("rsp_with_ready", 64'(cmd_ready), 64'(1));
               chk("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  chk("rsp_err", 64'(rsp_err), 64'(e.err));
                  chk("access_cycles", 64'(acc_cnt), 64'(e.acc));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned a1, a2, w, n;
      #1;
      chk("rst_pselx", 64'(pselx), 64'(0));
      chk("rst_penable", 64'(penable), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_paddr", 64'(paddr), 64'(0));
      chk("rst_pwdata", 64'(pwdata), 64'(0));
      repeat (3) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      chk("ready_after_reset", 64'(cmd_ready), 64'(1));

      issue(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, a1);
      idle_cycles(3);
      issue(1'b0, 8'h24, 32'h0, 3, 32'h12345678, 1'b0, a1);
      idle_cycles(6);
      issue(1'b0, 8'h31, 32'h0, 0, 32'hCAFEF00D, 1'b1, a1);
      issue(1'b1, 8'h32, 32'h01020304, 0, 32'h0, 1'b0, a2);
      chk("back_to_back_spacing", 64'(a2 - a1), 64'(3));
      issue(1'b0, 8'h33, 32'h0, TO - 1, 32'hA5A5A5A5, 1'b0, a1);
      issue(1'b0, 8'h34, 32'h0, TO, 32'h5A5A5A5A, 1'b0, a1);

      for (int i = 0; i < 40; i++) begin
         w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(0, 7);
         issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom, w, $urandom,
               1'($urandom_range(0, 3) == 0), a1);
         if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      end

      issue(1'b0, 8'h55, 32'h0, 120, 32'h87654321, 1'b0, a1);
`ifndef APB_MASTER_TIMEOUT_EN
      wait_access();
      for (int i = 0; i < 100; i++) begin
         @(negedge pclk);
         chk("no_watchdog_psel", 64'(pselx), 64'(1));
      end
`endif

      // Abort a transfer in ACCESS
      issue(1'b1, 8'h66, 32'h11223344, 10, 32'h0, 1'b0, a1);
      wait_access();
      @(negedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      chk("abort_pselx", 64'(pselx), 64'(0));
      chk("abort_penable", 64'(penable), 64'(0));
      chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("abort_paddr", 64'(paddr), 64'(0));
      chk("abort_pwrite", 64'(pwrite), 64'(0));
      chk("abort_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("abort_rsp_err", 64'(rsp_err), 64'(0));
      exp_q.delete();
      slv_q.delete();
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      chk("ready_after_abort", 64'(cmd_ready), 64'(1));
      chk("no_rsp_after_abort", 64'(rsp_valid), 64'(0));
      idle_cycles(3);
      issue(1'b0, 8'h77, 32'h0, 1, 32'h0BADF00D, 1'b0, a1);

      n = 0;
      idle_cycles(1);
      while (exp_q.size() > 0 && n < 500) begin
         @(negedge pclk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
      idle_cycles(3);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
